// File: rtl/lsu_bus_master.sv
// lsu_bus_master: one-outstanding load/store master; define LSU_MISALIGN_CHECK_EN to trap misaligned accesses via ERR.
// Latency from accept: load 3, store 2, misaligned 1; req_ready only in IDLE, rsp_valid pulse has no backpressure.
module lsu_bus_master #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [XLEN-1:0]   req_pc,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_misalign,
    output logic              bus_valid,
    output logic              bus_write,
    output logic [XLEN-1:0]   bus_addr,
    output logic [XLEN/8-1:0] bus_strobe,
    output logic [XLEN-1:0]   bus_wdata,
    output logic [XLEN-1:0]   bus_pc,
    output logic              bus_ifetch,
    input  logic [XLEN-1:0]   bus_rdata
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
`ifdef LSU_MISALIGN_CHECK_EN
    localparam logic [2:0] S_ERR   = 3'd4;
`endif

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic              r_write;
    logic              r_unsigned;
    logic [1:0]        r_size;
    logic [XLEN-1:0]   r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_rdata;

    logic              w_accept;
    logic              w_is_byte;
    logic              w_is_half;
    logic [1:0]        w_off;
    logic [XLEN-1:0]   w_shifted;
    logic [XLEN-1:0]   w_load_ext;
    logic [XLEN/8-1:0] w_strobe;
    logic [XLEN-1:0]   w_wdata_rep;

    assign w_accept  = req_valid && (r_state == S_IDLE);
    assign w_is_byte = (r_size == 2'd0);
    assign w_is_half = (r_size == 2'd1);

`ifdef LSU_MISALIGN_CHECK_EN
    logic w_req_misalign;
    assign w_req_misalign = ((req_size == 2'd1) && req_addr[0]) ||
                            (req_size[1] && (req_addr[1:0] != 2'b00));
    // Misaligned accesses never reach the bus, so the raw offset is always legal here.
    assign w_off = r_addr[1:0];
`else
    assign w_off = w_is_byte ? r_addr[1:0] :
                   w_is_half ? {r_addr[1], 1'b0} : 2'b00;
`endif

    assign w_shifted = bus_rdata >> {w_off, 3'b000};

    always_comb begin
        w_load_ext = w_shifted;
        if (w_is_byte) begin
            w_load_ext = {{(XLEN-8){~r_unsigned & w_shifted[7]}}, w_shifted[7:0]};
        end else if (w_is_half) begin
            w_load_ext = {{(XLEN-16){~r_unsigned & w_shifted[15]}}, w_shifted[15:0]};
        end
    end

    always_comb begin
        w_strobe    = '1;
        w_wdata_rep = r_wdata;
        if (w_is_byte) begin
            w_strobe    = 4'b0001 << w_off;
            w_wdata_rep = {4{r_wdata[7:0]}};
        end else if (w_is_half) begin
            w_strobe    = 4'b0011 << w_off;
            w_wdata_rep = {2{r_wdata[15:0]}};
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
`ifdef LSU_MISALIGN_CHECK_EN
                    w_next_state = w_req_misalign ? S_ERR : S_ISSUE;
`else
                    w_next_state = S_ISSUE;
`endif
                end
            end
            S_ISSUE: w_next_state = r_write ? S_RESP : S_WAIT;
            S_WAIT:  w_next_state = S_RESP;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state    <= S_IDLE;
            r_write    <= 1'b0;
            r_unsigned <= 1'b0;
            r_size     <= 2'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_pc       <= '0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_write    <= req_write;
                r_unsigned <= req_unsigned;
                r_size     <= req_size;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_pc       <= req_pc;
                r_rdata    <= '0;
            end
            // bus_rdata is only valid in the cycle after bus_valid, i.e. while in WAIT.
            if (r_state == S_WAIT) begin
                r_rdata <= w_load_ext;
            end
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign bus_valid  = (r_state == S_ISSUE);
    assign bus_write  = bus_valid & r_write;
    assign bus_addr   = {r_addr[XLEN-1:2], 2'b00};
    assign bus_strobe = bus_valid ? w_strobe : '0;
    assign bus_wdata  = w_wdata_rep;
    assign bus_pc     = r_pc;
    assign bus_ifetch = 1'b0;
    assign rsp_rdata  = (r_state == S_RESP) ? r_rdata : '0;

`ifdef LSU_MISALIGN_CHECK_EN
    assign rsp_valid    = (r_state == S_RESP) || (r_state == S_ERR);
    assign rsp_misalign = (r_state == S_ERR);
`else
    assign rsp_valid    = (r_state == S_RESP);
    assign rsp_misalign = 1'b0;
`endif

endmodule

// File: doc/lsu_bus_master.md
LSU_BUS_MASTER -- requirements
Module: lsu_bus_master

Interface
- REQ-001: Parameter XLEN, default 32, data/address width; only 32 is supported.
- REQ-002: clk  input  1  single clock, all state updates on rising edge.
- REQ-003: rst_b  input  1  reset, asynchronous, active-low.
- REQ-004: req_valid  input  1  core load/store request present.
- REQ-005: req_ready  output  1  request accepted when req_valid && req_ready at a rising edge.
- REQ-006: req_write  input  1  1 = store, 0 = load.
- REQ-007: req_addr  input  XLEN  byte address.
- REQ-008: req_size  input  2  0 = byte, 1 = halfword, 2 = word; 3 is treated as word.
- REQ-009: req_unsigned  input  1  zero-extend load data when 1, sign-extend when 0.
- REQ-010: req_wdata  input  XLEN  store data, right-aligned.
- REQ-011: req_pc  input  XLEN  pc of the issuing instruction, used for tracing.
- REQ-012: rsp_valid  output  1  single-cycle completion pulse; there is no backpressure.
- REQ-013: rsp_rdata  output  XLEN  extended load data; 0 for stores.
- REQ-014: rsp_misalign  output  1  completion flags a misaligned access.
- REQ-015: bus_valid, bus_write  output  1 each  memory request.
- REQ-016: bus_addr  output  XLEN  word-aligned address, req_addr with bits [1:0] = 0.
- REQ-017: bus_strobe  output  XLEN/8  byte enables.
- REQ-018: bus_wdata  output  XLEN  lane-replicated store data.
- REQ-019: bus_pc  output  XLEN  captured pc.
- REQ-020: bus_ifetch  output  1  tied 0.
- REQ-021: bus_rdata  input  XLEN  read data, valid exactly one cycle after the bus_valid cycle.

Function
- REQ-022: The FSM SHALL have the states IDLE, ISSUE, WAIT, RESP and ERR.
- REQ-023: req_ready SHALL be 1 only in IDLE; acceptance captures all req_* fields into registers.
- REQ-024: IDLE SHALL go to ISSUE on acceptance, or to ERR when the access is misaligned and LSU_MISALIGN_CHECK_EN is defined.
- REQ-025: ISSUE SHALL drive bus_valid=1 for exactly one cycle, then go to WAIT for a load or RESP for a store.
- REQ-026: WAIT SHALL register the extracted load data and go to RESP.
  - Extraction: bus_rdata >> (addr[1:0]*8).
  - Byte: extend from bit 7; halfword: extend from bit 15; word: unchanged.
  - Extension per req_unsigned.
- REQ-027: RESP SHALL assert rsp_valid for one cycle, then go to IDLE.
- REQ-028: ERR SHALL assert rsp_valid=1, rsp_misalign=1 and rsp_rdata=0 for one cycle, then go to IDLE; no bus_valid is issued.
- REQ-029: Latency from acceptance edge to rsp_valid high SHALL be: load 3 cycles, store 2 cycles, misaligned 1 cycle.
- REQ-030: bus_strobe SHALL be:
  - byte: 4'b0001 << addr[1:0]
  - halfword: 4'b0011 << addr[1:0]
  - word: 4'b1111
  - bus_strobe is 0 whenever bus_valid=0.
- REQ-031: bus_wdata SHALL be {4{wdata[7:0]}} for byte, {2{wdata[15:0]}} for halfword, and wdata for word.
- REQ-032: Misaligned SHALL mean halfword with addr[0]=1, or word with addr[1:0]≠0.
- REQ-033: All bus_* and rsp_* outputs SHALL be driven from registers or state only, with no combinational path from req_*.
- REQ-034: A new request presented during ISSUE, WAIT, RESP or ERR SHALL be held off (req_ready=0); back-to-back accepted requests are separated by at least one IDLE cycle.

Reset
- REQ-035: While rst_b=0 the FSM SHALL be in IDLE with req_ready=1 and all other outputs 0, including every captured register.
- REQ-036: Reset asserted mid-operation SHALL immediately drop bus_valid and rsp_valid, and the in-flight access SHALL produce no response.

Configuration
- REQ-037: With LSU_MISALIGN_CHECK_EN defined, misaligned requests SHALL follow the ERR path.
- REQ-038: Without LSU_MISALIGN_CHECK_EN:
  - the ERR state and misalignment logic are removed;
  - rsp_misalign is tied 0;
  - addr[0] is forced to 0 for halfword, and addr[1:0] to 0 for word, before strobe and lane computation.

Verification
- REQ-039: Word load: addr 0x80000004, bus_rdata 0xDEADBEEF -> one bus_valid cycle, strobe 4'hF, rsp_valid 3 cycles after acceptance, rsp_rdata 0xDEADBEEF.
- REQ-040: Signed byte load: addr 0x80000003, bus_rdata 0x80FF1234 -> rsp_rdata 0xFFFFFF80.
  - Same access with req_unsigned=1 -> rsp_rdata 0x00000080.
- REQ-041: Halfword store: addr 0x80000002, wdata 0x0000ABCD -> bus_write=1, strobe 4'b1100, bus_wdata 0xABCDABCD, rsp_valid 2 cycles after acceptance.
- REQ-042: Misaligned word load: addr 0x80000001 with LSU_MISALIGN_CHECK_EN -> no bus_valid, rsp_valid with rsp_misalign=1 one cycle after acceptance.
  - Without the macro -> bus_addr 0x80000000, strobe 4'hF.
- REQ-043: rst_b pulsed low during WAIT -> bus_valid=0 and rsp_valid=0 immediately, req_ready=1, and no response after release.
- REQ-044: req_valid held high for two consecutive requests -> req_ready low from ISSUE through RESP, and the second request is accepted only after returning to IDLE.
